// File: rtl/jtopl_acc_seq_if.sv
// Bus bundle for jtopl_acc_seq: operator enable, connection-register writes and per-slot attributes.
// The mute mask is present only when JTOPL_ACC_SEQ_MUTE_EN is defined.
interface jtopl_acc_seq_if;
   logic       cenop;
   logic       cfg_we;
   logic [3:0] cfg_ch;
   logic       cfg_con;
`ifdef JTOPL_ACC_SEQ_MUTE_EN
   logic [8:0] mute;
`endif
   logic       op;
   logic       con;
   logic       zero;
   logic [3:0] ch;
   logic       sample;

   modport master (
      output cenop, cfg_we, cfg_ch, cfg_con,
`ifdef JTOPL_ACC_SEQ_MUTE_EN
      output mute,
`endif
      input  op, con, zero, ch, sample
   );

   modport slave (
      input  cenop, cfg_we, cfg_ch, cfg_con,
`ifdef JTOPL_ACC_SEQ_MUTE_EN
      input  mute,
`endif
      output op, con, zero, ch, sample
   );
endinterface

// File: rtl/jtopl_acc_seq.sv
// OPL accumulator slot sequencer: walks 18 slots, delays {op,con,zero,ch} by DELAY cenop enables.
// No backpressure; optional per-channel mute with JTOPL_ACC_SEQ_MUTE_EN.
module jtopl_acc_seq #(
   parameter int DELAY = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   jtopl_acc_seq_if.slave bus
);
   logic [1:0]          r_sub;
   logic                r_opb;
   logic [1:0]          r_grp;
   logic [8:0]          r_con_bank;
   logic [DELAY:1]      r_op;
   logic [DELAY:1]      r_con;
   logic [DELAY:1]      r_zero;
   logic [DELAY:1][3:0] r_ch;
   logic                r_sample;

   logic [3:0]          w_ch_new;
   logic                w_zero_new;
   logic                w_mute;
   logic                w_op_new;
   logic                w_con_new;
   logic [DELAY:0]      w_op_c;
   logic [DELAY:0]      w_con_c;
   logic [DELAY:0]      w_zero_c;
   logic [DELAY:0][3:0] w_ch_c;

   assign w_ch_new   = ({2'b00, r_grp} << 1) + {2'b00, r_grp} + {2'b00, r_sub};
   assign w_zero_new = (r_sub == 2'd0) && !r_opb && (r_grp == 2'd0);
`ifdef JTOPL_ACC_SEQ_MUTE_EN
   assign w_mute     = bus.mute[w_ch_new];
`else
   assign w_mute     = 1'b0;
`endif
   assign w_op_new   = r_opb & ~w_mute;
   // Bank is read with the pre-write value, so a same-cycle write only affects later slots
   assign w_con_new  = r_con_bank[w_ch_new] & ~w_mute;

   // Bit 0 of each chain is the value entering stage 1; bit i is stage i
   assign w_op_c   = {r_op,   w_op_new};
   assign w_con_c  = {r_con,  w_con_new};
   assign w_zero_c = {r_zero, w_zero_new};
   assign w_ch_c   = {r_ch,   w_ch_new};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sub      <= 2'd0;
         r_opb      <= 1'b0;
         r_grp      <= 2'd0;
         r_con_bank <= '0;
         r_op       <= '0;
         r_con      <= '0;
         r_zero     <= '0;
         r_ch       <= '0;
         r_sample   <= 1'b0;
      end else begin
         for (int i = 0; i < 9; i++) begin
            if (bus.cfg_we && (bus.cfg_ch == 4'(i))) begin
               r_con_bank[i] <= bus.cfg_con;
            end
         end
         r_sample <= bus.cenop & w_zero_c[DELAY-1];
         if (bus.cenop) begin
            r_op   <= w_op_c[DELAY-1:0];
            r_con  <= w_con_c[DELAY-1:0];
            r_zero <= w_zero_c[DELAY-1:0];
            r_ch   <= w_ch_c[DELAY-1:0];
            if (r_sub == 2'd2) begin
               r_sub <= 2'd0;
               r_opb <= ~r_opb;
               if (r_opb) begin
                  r_grp <= (r_grp == 2'd2) ? 2'd0 : r_grp + 2'd1;
               end
            end else begin
               r_sub <= r_sub + 2'd1;
            end
         end
      end
   end

   assign bus.op     = r_op[DELAY];
   assign bus.con    = r_con[DELAY];
   assign bus.zero   = r_zero[DELAY];
   assign bus.ch     = r_ch[DELAY];
   assign bus.sample = r_sample;
endmodule

// File: tb/tb_jtopl_acc_seq.sv
// Bench for jtopl_acc_seq: DELAY=2 and DELAY=7 instances checked against a slot scoreboard.
module tb_jtopl_acc_seq;
   typedef struct packed {
      logic       op;
      logic       con;
      logic       zero;
      logic [3:0] ch;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst2_n;
   logic rst7_n;

   jtopl_acc_seq_if b2 ();
   jtopl_acc_seq_if b7 ();

   jtopl_acc_seq #(.DELAY(2)) u_dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2));
   jtopl_acc_seq #(.DELAY(7)) u_dut7 (.clk(clk), .rst_n(rst7_n), .bus(b7));

   int         n_chk  = 0;
   int         n_fail = 0;
   int         s    [2];
   logic [8:0] bank [2];
   exp_t       cur  [2];
   exp_t       q0 [$];
   exp_t       q1 [$];
   logic [8:0] mute_m = 9'h000;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t slot_attr(input int sn, input logic [8:0] bk);
      exp_t e;
      int   c;
      c      = 3 * (sn / 6) + (sn % 3);
      e.ch   = 4'(c);
      e.op   = ((sn % 6) >= 3);
      e.con  = bk[c];
      e.zero = (sn == 0);
`ifdef JTOPL_ACC_SEQ_MUTE_EN
      if (mute_m[c]) begin
         e.op  = 1'b0;
         e.con = 1'b0;
      end
`endif
      return e;
   endfunction

   function automatic logic [7:0] get_obs(input int sel);
      if (sel == 0) return {b2.op, b2.con, b2.zero, b2.ch, b2.sample};
      return {b7.op, b7.con, b7.zero, b7.ch, b7.sample};
   endfunction

   task automatic drive(input int sel, input logic en, input logic we,
                        input logic [3:0] wch, input logic wcon);
      b2.cenop   = (sel == 0) && en;
      b2.cfg_we  = (sel == 0) && we;
      b2.cfg_ch  = wch;
      b2.cfg_con = wcon;
      b7.cenop   = (sel == 1) && en;
      b7.cfg_we  = (sel == 1) && we;
      b7.cfg_ch  = wch;
      b7.cfg_con = wcon;
`ifdef JTOPL_ACC_SEQ_MUTE_EN
      b2.mute    = mute_m;
      b7.mute    = mute_m;
`endif
   endtask

   // One clk: push the slot being counted, pop the one due at the output.
   task automatic step(input int sel, input logic en, input logic we,
                       input logic [3:0] wch, input logic wcon, input string tag);
      exp_t e;
      logic es;
      drive(sel, en, we, wch, wcon);
      e  = cur[sel];
      es = 1'b0;
      if (en) begin
         if (sel == 0) begin
            q0.push_back(slot_attr(s[0], bank[0]));
            e = q0.pop_front();
         end else begin
            q1.push_back(slot_attr(s[1], bank[1]));
            e = q1.pop_front();
         end
         s[sel] = (s[sel] + 1) % 18;
         es     = e.zero;
      end
      if (we && (wch <= 4'd8)) bank[sel][wch] = wcon;
      @(posedge clk);
      #1;
      chk(tag, {24'd0, get_obs(sel)}, {24'd0, e, es});
      cur[sel] = e;
   endtask

   task automatic do_reset(input int sel);
      drive(sel, 1'b1, 1'b1, 4'd0, 1'b1);
      if (sel == 0) rst2_n = 1'b0; else rst7_n = 1'b0;
      @(posedge clk);
      #1;
      chk(sel == 0 ? "reset_d2" : "reset_d7", {24'd0, get_obs(sel)}, 32'd0);
      if (sel == 0) rst2_n = 1'b1; else rst7_n = 1'b1;
      s[sel]    = 0;
      bank[sel] = '0;
      cur[sel]  = '0;
      if (sel == 0) begin
         q0.delete();
         q0.push_back('0);
      end else begin
         q1.delete();
         for (int k = 0; k < 6; k++) q1.push_back('0);
      end
   endtask

   initial begin
      rst2_n = 1'b0;
      rst7_n = 1'b0;
      drive(0, 1'b0, 1'b0, 4'd0, 1'b0);
      @(posedge clk);
      #1;
      do_reset(0);
      do_reset(1);

      // DELAY=2, continuous enables: first frame start and first carrier slot
      step(0, 1'b1, 1'b0, 4'd0, 1'b0, "en1");
      step(0, 1'b1, 1'b0, 4'd0, 1'b0, "en2");
      chk("first_zero", {25'd0, b2.zero, b2.ch, b2.op, b2.sample}, {25'd0, 1'b1, 4'd0, 1'b0, 1'b1});
      step(0, 1'b1, 1'b0, 4'd0, 1'b0, "en3");
      chk("sample_fall", {31'd0, b2.sample}, 32'd0);
      step(0, 1'b1, 1'b0, 4'd0, 1'b0, "en4");
      step(0, 1'b1, 1'b0, 4'd0, 1'b0, "en5");
      chk("car0", {27'd0, b2.ch, b2.op}, {27'd0, 4'd0, 1'b1});
      for (int i = 0; i < 36; i++) step(0, 1'b1, 1'b0, 4'd0, 1'b0, "frame");

      // Connection writes without enable; channel 12 must be ignored
      step(0, 1'b0, 1'b1, 4'd4, 1'b1, "wr_ch4");
      step(0, 1'b0, 1'b1, 4'd12, 1'b1, "wr_ch12");
      for (int i = 0; i < 20; i++) step(0, 1'b1, 1'b0, 4'd0, 1'b0, "con_ch4");

      // Write ch3 on the very enable that loads slot 6
      for (int i = 0; i < 18 && s[0] != 6; i++) step(0, 1'b1, 1'b0, 4'd0, 1'b0, "to_s6");
      step(0, 1'b1, 1'b1, 4'd3, 1'b1, "collide");
      for (int i = 0; i < 22; i++) step(0, 1'b1, 1'b0, 4'd0, 1'b0, "post_coll");

      // DELAY=7 at 1/3 enable rate, then reset mid-frame and restart
      step(1, 1'b0, 1'b1, 4'd0, 1'b1, "d7_wr_ch0");
      for (int i = 0; i < 50; i++) step(1, (i % 3) == 2, 1'b0, 4'd0, 1'b0, "d7_slow");
      chk("d7_pre_rst_nz", {31'd0, (get_obs(1) != 8'd0)}, 32'd1);
      do_reset(1);
      for (int i = 0; i < 66; i++) step(1, (i % 3) == 0, 1'b0, 4'd0, 1'b0, "d7_restart");

`ifdef JTOPL_ACC_SEQ_MUTE_EN
      mute_m = 9'h004;
      step(0, 1'b0, 1'b1, 4'd2, 1'b1, "m_wr_ch2");
      step(0, 1'b0, 1'b1, 4'd1, 1'b1, "m_wr_ch1");
      for (int i = 0; i < 24; i++) step(0, 1'b1, 1'b0, 4'd0, 1'b0, "mute");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/jtopl_acc_seq.md
# jtopl_acc_seq

Slot sequencer and connection-register bank that drives the per-operator control inputs of the OPL output accumulator. The block walks the 18 operator slots (9 channels × modulator/carrier) on the operator clock enable. It delays the slot attributes by a programmable number of enables so they line up with the operator pipeline's `op_result`. It generates `op`, `con`, `zero` and a one-cycle `sample` strobe for the accumulator.

## Interface
- `DELAY`, default 2: number of `cenop` enables between a slot being counted and its attributes appearing on the outputs. Legal range 1..7.
- `clk` input 1: system clock.
- `rst_n` input 1: synchronous reset, active-low.
- `cenop` input 1: operator clock enable; everything except config writes advances only when high.
- `cfg_we` input 1: connection register write strobe.
- `cfg_ch` input 4: channel being written, 0..8; writes with values 9..15 are ignored.
- `cfg_con` input 1: connection bit to store (0 = FM, 1 = additive).
- `mute` input 9: per-channel mute mask. Present only with `JTOPL_ACC_SEQ_MUTE_EN`.
- `op` output 1: 0 = modulator slot, 1 = carrier slot.
- `con` output 1: connection bit of the output slot's channel.
- `zero` output 1: output slot is slot 0, the first of the frame.
- `ch` output 4: channel of the output slot, 0..8.
- `sample` output 1: one-clk pulse marking the start of a new frame sum.

## Operation
- Slot counter S runs 0..17 and wraps 17 → 0. It is implemented as fields `sub` (0..2), `opb` (0..1) and `grp` (0..2), with `sub` fastest.
  - Attributes of slot S: `op` = (S mod 6) ≥ 3.
  - `ch` = 3·(S div 6) + (S mod 3).
  - `zero` = (S == 0).
  - Resulting order: S 0..2 = mod ch0..2; S 3..5 = car ch0..2; S 6..8 = mod ch3..5; and so on up to S 15..17 = car ch6..8.
- `con` register bank holds 9 bits.
  - A write happens on any clk with `cfg_we`=1 and `cfg_ch`≤8, independent of `cenop`.
- Pipeline has DELAY stages of {op, zero, ch, con}.
  - On each enable, stage 1 ← attributes(S) with `con` read from the bank, stage i ← stage i−1, and S ← S+1 mod 18.
  - Outputs are stage DELAY, driven directly from registers.
- `con` is sampled into stage 1 at load time. Later writes do not affect slots already in flight.
- Same-cycle write and stage-1 load for the same channel: the load takes the old value; the new value applies from the next enable onward.
- `sample` goes high on the clk edge where stage DELAY loads `zero`=1. It falls on the next clk edge, regardless of `cenop`.

## Timing
- Reset, when `rst_n`=0 at a clk edge:
  - S=0.
  - All pipeline stages cleared: `op`=0, `zero`=0, `con`=0, `ch`=0.
  - `sample`=0.
  - `con` bank cleared to 0.
- Reset takes priority over `cenop` and `cfg_we`.
- Reset mid-frame discards all in-flight slots. The next frame restarts at slot 0.
- Latency: the attributes of slot S counted at enable k appear on the outputs after enable k+DELAY−1.
  - The first `zero`=1 after reset appears after DELAY enables.
  - Before that, outputs hold their reset values, so `op`|`con`=0 and nothing is summed.
- Outputs are stable between enables. With `cenop` held low, nothing changes except the `con` bank and the falling edge of `sample`.
- `sample` period = 18 enables. It never lasts more than one clk, even with `cenop` high continuously.

## Configuration
- `JTOPL_ACC_SEQ_MUTE_EN` defined:
  - The `mute` port exists.
  - At stage-1 load, if `mute[ch]`=1, the stored `op` and `con` are forced to 0, so the slot is excluded from the sum.
  - `zero` and `ch` are unaffected.
- Not defined:
  - No `mute` port.
  - `op` and `con` come straight from the slot attributes and the bank.

## Test plan
- Reset with DELAY=2, then `cenop` every cycle:
  - After the 2nd enable: `zero`=1, `ch`=0, `op`=0, and `sample`=1 for one clk.
  - After the 5th enable: `ch`=0, `op`=1.
  - `sample` repeats every 18 clks.
- Full frame check: the sequence of `ch`/`op` over 18 enables equals 0m,1m,2m,0c,1c,2c,3m,4m,5m,3c,4c,5c,6m,7m,8m,6c,7c,8c.
- Write `cfg_ch`=4, `cfg_con`=1:
  - Slot ch4 car (S=10) shows `con`=1; all other channels show `con`=0.
  - A write with `cfg_ch`=12 leaves the bank unchanged.
- Same-cycle collision: write ch3 `con`=1 on the clk where S=6 loads.
  - That slot outputs `con`=0.
  - S=9 (ch3 car) in the same frame outputs `con`=1.
- `cenop` toggling at 1/3 rate with DELAY=7:
  - Outputs change only on enables.
  - `sample` stays a single clk.
  - Reset asserted mid-frame returns all outputs to 0 on the next clk.
- With `JTOPL_ACC_SEQ_MUTE_EN`, `mute`=9'h004 and `con[2]`=1: slots of ch2 output `op`=0 and `con`=0; ch1 is unaffected.
